// File: rtl/debounce_multi.sv
// Multi-channel push-button / switch debouncer: per-channel synchroniser, FSM and counter,
// producing a debounced level plus one-cycle rise and fall ticks.
module debounce_multi #(
    parameter int CH          = 4,
    parameter int DB_CYCLES   = 4_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic [CH-1:0] btn,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [CH-1:0]          s;

    state_t                 state      [CH];
    state_t                 state_next [CH];
    logic [CNT_W-1:0]       cnt        [CH];
    logic [CNT_W-1:0]       cnt_next   [CH];
    logic [CH-1:0]          level_next;
    logic [CH-1:0]          rise_next;
    logic [CH-1:0]          fall_next;

    // Bit 0 of each chain takes the raw pin; the FSM only looks at the last stage.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            level_next[i] = db_level[i];
            rise_next[i]  = 1'b0;
            fall_next[i]  = 1'b0;
            case (state[i])
                ZERO: begin
                    if (s[i]) begin
                        state_next[i] = WAIT1;
                        cnt_next[i]   = RELOAD;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_next[i] = ZERO;
                    end else if (cnt[i] == '0) begin
                        state_next[i] = ONE;
                        level_next[i] = 1'b1;
                        rise_next[i]  = 1'b1;
                    end else begin
                        cnt_next[i] = cnt[i] - CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_next[i] = WAIT0;
                        cnt_next[i]   = RELOAD;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_next[i] = ONE;
                    end else if (cnt[i] == '0) begin
                        state_next[i] = ZERO;
                        level_next[i] = 1'b0;
                        fall_next[i]  = 1'b1;
                    end else begin
                        cnt_next[i] = cnt[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_next[i] = ZERO;
                    level_next[i] = 1'b0;
                end
            endcase
        end
    end

    // Level and ticks are registered so consumers see glitch-free, aligned outputs.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= ZERO;
                cnt[i]   <= '0;
            end
            db_level <= '0;
            db_rise  <= '0;
            db_fall  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            db_level <= level_next;
            db_rise  <= rise_next;
            db_fall  <= fall_next;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random bouncing,
// compared every cycle against a run-length reference model.
module tb_debounce_multi;

    localparam int CH          = 4;
    localparam int DB_CYCLES   = 8;
    localparam int SYNC_STAGES = 2;

    logic          clk_100MHz;
    logic          reset;
    logic [CH-1:0] btn;
    logic [CH-1:0] db_level;
    logic [CH-1:0] db_rise;
    logic [CH-1:0] db_fall;

    int n_compared   = 0;
    int n_mismatched = 0;

    debounce_multi #(
        .CH          (CH),
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn        (btn),
        .db_level   (db_level),
        .db_rise    (db_rise),
        .db_fall    (db_fall)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: a channel flips once its synchronised input has disagreed with the
    // current level for DB_CYCLES+1 consecutive edges; any agreeing sample restarts the run.
    logic [CH-1:0] pipe [$];
    logic [CH-1:0] s_seen;
    logic [CH-1:0] exp_level;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
    int            run [CH];

    always @(posedge clk_100MHz) begin
        exp_rise = '0;
        exp_fall = '0;
        if (reset) begin
            pipe.delete();
            for (int k = 0; k < SYNC_STAGES; k++) pipe.push_back('0);
            exp_level = '0;
            for (int c = 0; c < CH; c++) run[c] = 0;
        end else begin
            s_seen = pipe.pop_front();
            pipe.push_back(btn);
            for (int c = 0; c < CH; c++) begin
                if (s_seen[c] != exp_level[c]) begin
                    run[c]++;
                    if (run[c] == DB_CYCLES + 1) begin
                        exp_level[c] = s_seen[c];
                        run[c]       = 0;
                        if (s_seen[c]) exp_rise[c] = 1'b1;
                        else           exp_fall[c] = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        #1;
        checkOutput("db_level", 32'(db_level), 32'(exp_level));
        checkOutput("db_rise", 32'(db_rise), 32'(exp_rise));
        checkOutput("db_fall", 32'(db_fall), 32'(exp_fall));
        checkOutput("rise_fall_excl", 32'(db_rise & db_fall), 32'd0);
    end

    task automatic applyStimulus(input logic [CH-1:0] value, input int hold);
        btn = value;
        repeat (hold) @(negedge clk_100MHz);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 32'({db_level, db_rise, db_fall}), 32'd0);
        @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn   = '1;
        repeat (5) @(negedge clk_100MHz);
        checkOutput("held_in_reset", 32'({db_level, db_rise, db_fall}), 32'd0);
        reset = 1'b0;
        applyStimulus(4'hF, 14);
        applyStimulus(4'h0, 14);

        applyStimulus(4'h1, 14);
        applyStimulus(4'h0, 14);

        for (int k = 0; k < 10; k++) applyStimulus((k % 2 == 0) ? 4'h2 : 4'h0, 3);
        applyStimulus(4'h2, 14);
        applyStimulus(4'h0, 14);

        applyStimulus(4'h4, 14);
        applyStimulus(4'h0, 1);
        applyStimulus(4'h4, 14);
        applyStimulus(4'h0, 14);

        applyStimulus(4'h7, 4);
        applyStimulus(4'hF, 14);
        applyStimulus(4'h0, 16);

        applyStimulus(4'h1, 7);
        pulseReset();
        applyStimulus(4'h1, 14);
        applyStimulus(4'h0, 14);

        // Random bouncing with occasional mid-operation resets.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 24) == 0) pulseReset();
            applyStimulus(CH'($urandom), $urandom_range(1, 14));
        end
        applyStimulus(4'h0, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
